wb_unit: RTL and testbench

// Write-back stage directly upstream of the RV32E register file. Accepts one retired

---
 rtl/wb_unit.sv | 156 +++++++++++++++
 tb/tb_wb_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - RV32E write-back stage: load alignment/extension, register file write, sticky load error
`timescale 1ns/1ps

module wb_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic            ex_wen,
  input  logic            ex_is_load,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_alu_res,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wen_reg,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rin,
  output logic            commit,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT, ERR} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        rd_lat_q, rd_lat_d;
  logic              wen_lat_q, wen_lat_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_q, addr_d;
  logic              wen_reg_q, wen_reg_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   rin_q, rin_d;
  logic              commit_q, commit_d;
  logic              err_q, err_d;

  logic              bad_load;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_data;

  always_comb begin
    bad_load = 1'b0;
    case (ex_funct3)
      3'b000, 3'b100: bad_load = 1'b0;
      3'b001, 3'b101: bad_load = ex_alu_res[0];
      3'b010:         bad_load = (ex_alu_res[1:0] != 2'b00);
      default:        bad_load = 1'b1;
    endcase
  end

  // Halfword loads are 2-byte aligned, so a byte-granular shift also selects the right half.
  always_comb begin
    shifted   = mem_rdata >> {addr_q, 3'b000};
    load_data = shifted;
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_lat_d  = rd_lat_q;
    wen_lat_d = wen_lat_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wen_reg_d = 1'b0;
    rd_d      = rd_q;
    rin_d     = rin_q;
    commit_d  = 1'b0;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          rd_lat_d  = ex_rd;
          wen_lat_d = ex_wen;
          funct3_d  = ex_funct3;
          addr_d    = ex_alu_res[1:0];
          if (!ex_is_load) begin
            state_d   = COMMIT;
            rd_d      = ex_rd;
            rin_d     = ex_alu_res;
            wen_reg_d = ex_wen;
            commit_d  = 1'b1;
          end else if (bad_load) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = WAIT_MEM;
            cnt_d   = '0;
          end
        end
      end
      WAIT_MEM: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Data arriving in the final timeout cycle still commits.
        if (mem_rvalid) begin
          state_d   = COMMIT;
          rd_d      = rd_lat_q;
          rin_d     = load_data;
          wen_reg_d = wen_lat_q;
          commit_d  = 1'b1;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_lat_q  <= '0;
      wen_lat_q <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wen_reg_q <= 1'b0;
      rd_q      <= '0;
      rin_q     <= '0;
      commit_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_lat_q  <= rd_lat_d;
      wen_lat_q <= wen_lat_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wen_reg_q <= wen_reg_d;
      rd_q      <= rd_d;
      rin_q     <= rin_d;
      commit_q  <= commit_d;
      err_q     <= err_d;
    end
  end

  assign ex_ready = (state_q == IDLE);
  assign wen_reg  = wen_reg_q;
  assign rd       = rd_q;
  assign rin      = rin_q;
  assign commit   = commit_q;
  assign err      = err_q;

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - directed self-checking bench for wb_unit
`timescale 1ns/1ps

module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_res;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wen_reg;
  logic [4:0]  rd;
  logic [31:0] rin;
  logic        commit;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  wb_unit #(.XLEN(32), .MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_rd      (ex_rd),
    .ex_wen     (ex_wen),
    .ex_is_load (ex_is_load),
    .ex_funct3  (ex_funct3),
    .ex_alu_res (ex_alu_res),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wen_reg    (wen_reg),
    .rd         (rd),
    .rin        (rin),
    .commit     (commit),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ex_valid = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic issue(input logic [4:0] r, input logic w, input logic ld,
                       input logic [2:0] f3, input logic [31:0] a);
    int n = 0;
    while (!ex_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ex_ready) check("ready_wait", 32'(ex_ready), 32'd1);
    ex_valid   = 1'b1;
    ex_rd      = r;
    ex_wen     = w;
    ex_is_load = ld;
    ex_funct3  = f3;
    ex_alu_res = a;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] a,
                         input logic [31:0] data, input logic [31:0] exp);
    issue(5'd9, 1'b1, 1'b1, f3, {30'h0000_0100, a});
    repeat (2) begin @(posedge clk); #1; end
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check({tag, "_commit"}, {30'd0, wen_reg, commit}, 32'd3);
    check({tag, "_rin"}, rin, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    logic bad;
    rst = 1'b0;
    ex_valid = 1'b0; ex_rd = '0; ex_wen = 1'b0; ex_is_load = 1'b0;
    ex_funct3 = '0; ex_alu_res = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    check("reset_outs", {24'd0, wen_reg, commit, err, rd}, 32'd0);
    check("reset_rin", rin, 32'd0);
    @(negedge clk); rst = 1'b1;
    #1;
    check("reset_ready", 32'(ex_ready), 32'd1);

    // ALU op commits in the very next cycle
    issue(5'd5, 1'b1, 1'b0, 3'b000, 32'h1234_5678);
    check("alu_wen_commit", {30'd0, wen_reg, commit}, 32'd3);
    check("alu_rd", 32'(rd), 32'd5);
    check("alu_rin", rin, 32'h1234_5678);
    check("alu_ready_busy", 32'(ex_ready), 32'd0);
    @(posedge clk); #1;
    check("alu_after", {29'd0, ex_ready, wen_reg, commit}, 32'd4);
    check("alu_rin_hold", rin, 32'h1234_5678);

    do_load("lb",  3'b000, 2'b11, 32'h80FF_FF7F, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 2'b11, 32'h80FF_FF7F, 32'h0000_0080);
    do_load("lb0", 3'b000, 2'b00, 32'h80FF_FF7F, 32'h0000_007F);
    do_load("lh",  3'b001, 2'b10, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 2'b10, 32'h8001_1234, 32'h0000_8001);
    do_load("lw",  3'b010, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check("load_rd", 32'(rd), 32'd9);

    // rvalid in the 16th WAIT_MEM cycle still commits
    issue(5'd3, 1'b1, 1'b1, 3'b010, 32'h0000_0040);
    repeat (15) begin @(posedge clk); #1; end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("late_commit", {29'd0, err, wen_reg, commit}, 32'd3);
    check("late_rin", rin, 32'hCAFE_F00D);
    @(posedge clk); #1;

    // no rvalid: error after 16 WAIT_MEM cycles, never a write
    issue(5'd4, 1'b1, 1'b1, 3'b010, 32'h0000_0080);
    bad = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (err || wen_reg || commit || ex_ready) bad = 1'b1;
    end
    check("timeout_quiet", 32'(bad), 32'd0);
    @(posedge clk); #1;
    check("timeout_err", {29'd0, err, ex_ready, wen_reg}, 32'd4);
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("timeout_sticky", {29'd0, err, ex_ready, wen_reg}, 32'd4);
    do_reset();
    #1;

    // misaligned lw errors immediately, later rvalid ignored
    issue(5'd6, 1'b1, 1'b1, 3'b010, 32'h0000_0041);
    check("lw_misalign", {29'd0, err, commit, wen_reg}, 32'd4);
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("lw_misalign_ignore", {28'd0, err, ex_ready, commit, wen_reg}, 32'd8);
    do_reset();
    #1;

    issue(5'd6, 1'b1, 1'b1, 3'b011, 32'h0000_0040);
    check("bad_funct3", {29'd0, err, commit, wen_reg}, 32'd4);
    do_reset();
    #1;
    issue(5'd6, 1'b1, 1'b1, 3'b101, 32'h0000_0043);
    check("lhu_misalign", {29'd0, err, commit, wen_reg}, 32'd4);
    do_reset();
    #1;

    // async reset in the middle of WAIT_MEM
    issue(5'd7, 1'b1, 1'b0, 3'b000, 32'hA5A5_5A5A);
    @(posedge clk); #1;
    issue(5'd8, 1'b1, 1'b1, 3'b010, 32'h0000_0010);
    @(posedge clk); #2;
    check("pre_rst_rin", rin, 32'hA5A5_5A5A);
    rst = 1'b0;
    #1;
    check("async_rst_outs", {24'd0, wen_reg, commit, err, rd}, 32'd0);
    check("async_rst_rin", rin, 32'd0);
    @(negedge clk); rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(ex_ready), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check("stray_rvalid", {27'd0, ex_ready, err, commit, wen_reg, 1'b0}, 32'd16);
    check("stray_rin", rin, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
